// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MUL/MLA/SDIV/UDIV engine, one shift-add or restoring-divide step per cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, c_q, c_d, result_q, result_d;
  logic [WIDTH:0] acc_q, acc_d, rem_sh, diff;
  logic neg_q, neg_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
  logic accept, is_div, is_sdiv_in;
  logic [WIDTH-1:0] abs_a, abs_b, quo_n, prod_n;
  // x holds multiplicand (shifting left) or dividend/quotient; y holds multiplier (shifting right) or divisor magnitude
  always_comb begin
    accept     = start && state_q != RUN;
    is_div     = op_q[1];
    is_sdiv_in = op == 2'b10;
    abs_a      = (is_sdiv_in && a[WIDTH-1]) ? -a : a;
    abs_b      = (is_sdiv_in && b[WIDTH-1]) ? -b : b;
    rem_sh     = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    diff       = rem_sh - {1'b0, y_q};
    quo_n      = {x_q[WIDTH-2:0], ~diff[WIDTH]};
    prod_n     = acc_q[WIDTH-1:0] + (y_q[0] ? x_q : '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    if (accept) begin
      state_d = RUN;
      cnt_d   = CW'(WIDTH);
      op_d    = op;
      x_d     = abs_a;
      y_d     = abs_b;
      c_d     = c;
      acc_d   = '0;
      neg_d   = is_sdiv_in && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = is_div ? (diff[WIDTH] ? rem_sh : diff) : {1'b0, prod_n};
      x_d   = is_div ? quo_n : x_q << 1;
      y_d   = is_div ? y_q : y_q >> 1;
      if (cnt_q == CW'(1)) begin
        state_d  = DONE;
        dbz_d    = is_div && y_q == '0;
        result_d = is_div ? (y_q == '0 ? '0 : (neg_q ? -quo_n : quo_n))
                          : prod_n + (op_q == 2'b01 ? c_q : '0);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of a 32-bit and an 8-bit muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start8 = 1'b0;
  logic [1:0] op = '0, op8 = '0;
  logic [31:0] a = '0, b = '0, c = '0, res;
  logic [7:0] a8 = '0, b8 = '0, c8 = '0, res8;
  logic busy, done, dbz, busy8, done8, dbz8;
  int checks = 0, errors = 0;
  logic [31:0] last32 = '0, last8 = '0;
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .result(res), .div_by_zero(dbz));
  muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .result(res8), .div_by_zero(dbz8));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic go(input bit w8, input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                    input logic [31:0] ic, input int pulse, input logic [31:0] er, input logic edz, input string tag);
    int n, bc, lat;
    lat = w8 ? 9 : 33;
    @(negedge clk);
    if (w8) begin op8 = o; a8 = ia[7:0]; b8 = ib[7:0]; c8 = ic[7:0]; start8 = 1'b1; end
    else begin op = o; a = ia; b = ib; c = ic; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    n = 1; bc = 0;
    while (!(w8 ? done8 : done) && n < 100) begin
      if (w8 ? busy8 : busy) bc++;
      if (n == 4) chk({tag, " hold"}, w8 ? {24'd0, res8} : res, w8 ? last8 : last32);
      start = (n == pulse);
      if (n == pulse) begin op = 2'b11; a = 32'd99; b = 32'd9; c = 32'd5; end
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy"}, bc, lat - 1);
    chk({tag, " result"}, w8 ? {24'd0, res8} : res, er);
    chk({tag, " dbz"}, w8 ? dbz8 : dbz, edz);
    if (w8) last8 = er; else last32 = er;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", res, 0);
    chk("rst dbz", dbz, 0);
    chk("rst8 result", res8, 0);
    rst_n = 1'b1;
    go(0, 2'b01, 32'd10, 32'd5, 32'd2, 0, 32'h34, 0, "mla");
    go(0, 2'b00, 32'd10, 32'd5, 32'd2, 0, 32'd50, 0, "mul");
    go(0, 2'b10, 32'd10, 32'd5, 32'd0, 0, 32'd2, 0, "sdiv pos");
    go(0, 2'b10, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 32'hFFFFFFFD, 0, "sdiv neg");
    go(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 32'h80000000, 0, "sdiv ovf");
    go(0, 2'b11, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 32'h7FFFFFFC, 0, "udiv");
    go(0, 2'b11, 32'd123, 32'd0, 32'd0, 0, 32'd0, 1, "udiv zero");
    go(0, 2'b00, 32'd3, 32'd4, 32'd0, 0, 32'd12, 0, "mul after dbz");
    go(0, 2'b00, 32'd6, 32'd7, 32'd0, 5, 32'd42, 0, "mul ignore start");
    // back-to-back: start held high through DONE, operands changed after acceptance
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7;
    n = 1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("b2b first latency", n, 33);
    chk("b2b first result", res, 25);
    @(negedge clk);
    start = 1'b0;
    chk("b2b no idle", busy, 1);
    n = 1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("b2b second latency", n, 33);
    chk("b2b second result", res, 14);
    // reset in the middle of a divide
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst result", res, 0);
    last32 = '0;
    last8 = '0;
    go(0, 2'b11, 32'd100, 32'd7, 32'd0, 0, 32'd14, 0, "udiv after rst");
    go(1, 2'b01, 32'd15, 32'd17, 32'd1, 0, 32'h00, 0, "w8 mla");
    go(1, 2'b10, 32'h80, 32'hFF, 32'd0, 0, 32'h80, 0, "w8 sdiv ovf");
    go(1, 2'b11, 32'd200, 32'd3, 32'd0, 0, 32'd66, 0, "w8 udiv");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
